// File: rtl/truth_table_checker.sv
// truth_table_checker
// Sweeps every N_IN-bit input vector into a combinational DUT, holds each
// vector for HOLD cycles, compares the DUT output against the TRUTH table on
// the last hold cycle, and repeats the sweep REPEAT times.
//
// Ports
//   clk             in   clock, rising edge
//   rst             in   asynchronous active-high reset
//   start           in   begin a run (accepted only in IDLE)
//   dut_out         in   DUT output under test (synchronous to clk)
//   stim            out  N_IN-bit vector driven to the DUT inputs
//   busy            out  high while a run is in progress
//   done            out  one-cycle pulse when a run completes
//   pass            out  last completed run had zero mismatches
//   err_count       out  mismatches in current/last run, saturating
//   first_err_vec   out  stim value of the first mismatch in the run
//   first_err_valid out  first_err_vec is meaningful
module truth_table_checker #(
    parameter int unsigned          N_IN   = 3,
    parameter int unsigned          HOLD   = 2,
    parameter int unsigned          REPEAT = 2,
    parameter logic [(1<<N_IN)-1:0] TRUTH  = 8'hE8,
    parameter int unsigned          CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dut_out,
    output logic [N_IN-1:0]   stim,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [N_IN-1:0]   first_err_vec,
    output logic              first_err_valid
);

    localparam int unsigned N_VEC   = 1 << N_IN;
    localparam int unsigned HOLD_W  = (HOLD > 1)   ? $clog2(HOLD)   : 1;
    localparam int unsigned SWEEP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    localparam logic [N_IN-1:0]    STIM_LAST  = N_IN'(N_VEC - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD - 1);
    localparam logic [SWEEP_W-1:0] SWEEP_LAST = SWEEP_W'(REPEAT - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t               r_state;
    logic [N_IN-1:0]      r_stim;
    logic [HOLD_W-1:0]    r_hold_cnt;
    logic [SWEEP_W-1:0]   r_sweep_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic [CNT_W-1:0]     r_err_count;
    logic [N_IN-1:0]      r_first_err_vec;
    logic                 r_first_err_valid;

    state_t               w_state_nxt;
    logic [N_IN-1:0]      w_stim_nxt;
    logic [HOLD_W-1:0]    w_hold_cnt_nxt;
    logic [SWEEP_W-1:0]   w_sweep_cnt_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;
    logic                 w_pass_nxt;
    logic [CNT_W-1:0]     w_err_count_nxt;
    logic [N_IN-1:0]      w_first_err_vec_nxt;
    logic                 w_first_err_valid_nxt;

    logic                 w_cmp_en;
    logic                 w_mismatch;
    logic [CNT_W-1:0]     w_err_inc;

    // Compare happens on the last cycle a vector is held.
    assign w_cmp_en   = (r_state == S_RUN) && (r_hold_cnt == HOLD_LAST);
    assign w_mismatch = w_cmp_en && (dut_out != TRUTH[r_stim]);
    assign w_err_inc  = (r_err_count == CNT_MAX) ? r_err_count
                                                 : r_err_count + CNT_W'(1);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_stim            <= '0;
            r_hold_cnt        <= '0;
            r_sweep_cnt       <= '0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_err_count       <= '0;
            r_first_err_vec   <= '0;
            r_first_err_valid <= 1'b0;
        end else begin
            r_state           <= w_state_nxt;
            r_stim            <= w_stim_nxt;
            r_hold_cnt        <= w_hold_cnt_nxt;
            r_sweep_cnt       <= w_sweep_cnt_nxt;
            r_busy            <= w_busy_nxt;
            r_done            <= w_done_nxt;
            r_pass            <= w_pass_nxt;
            r_err_count       <= w_err_count_nxt;
            r_first_err_vec   <= w_first_err_vec_nxt;
            r_first_err_valid <= w_first_err_valid_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt           = r_state;
        w_stim_nxt            = r_stim;
        w_hold_cnt_nxt        = r_hold_cnt;
        w_sweep_cnt_nxt       = r_sweep_cnt;
        w_busy_nxt            = 1'b0;
        w_done_nxt            = 1'b0;
        w_pass_nxt            = r_pass;
        w_err_count_nxt       = r_err_count;
        w_first_err_vec_nxt   = r_first_err_vec;
        w_first_err_valid_nxt = r_first_err_valid;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt           = S_RUN;
                    w_busy_nxt            = 1'b1;
                    w_stim_nxt            = '0;
                    w_hold_cnt_nxt        = '0;
                    w_sweep_cnt_nxt       = '0;
                    w_err_count_nxt       = '0;
                    w_first_err_vec_nxt   = '0;
                    w_first_err_valid_nxt = 1'b0;
                    w_pass_nxt            = 1'b0;
                end
            end

            S_RUN: begin
                w_busy_nxt = 1'b1;

                if (w_mismatch) begin
                    w_err_count_nxt = w_err_inc;
                    // Only the first mismatch of the run is captured.
                    if (!r_first_err_valid) begin
                        w_first_err_vec_nxt   = r_stim;
                        w_first_err_valid_nxt = 1'b1;
                    end
                end

                if (w_cmp_en) begin
                    w_hold_cnt_nxt = '0;
                    if (r_stim == STIM_LAST) begin
                        w_stim_nxt = '0;
                        if (r_sweep_cnt == SWEEP_LAST) begin
                            w_state_nxt     = S_FINISH;
                            w_busy_nxt      = 1'b0;
                            w_done_nxt      = 1'b1;
                            w_sweep_cnt_nxt = '0;
                            // Includes the result of the final compare.
                            w_pass_nxt      = (w_err_count_nxt == '0);
                        end else begin
                            w_sweep_cnt_nxt = r_sweep_cnt + SWEEP_W'(1);
                        end
                    end else begin
                        w_stim_nxt = r_stim + N_IN'(1);
                    end
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end

            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign stim            = r_stim;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_count       = r_err_count;
    assign first_err_vec   = r_first_err_vec;
    assign first_err_valid = r_first_err_valid;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: three instances (defaults, CNT_W=3,
// HOLD=1/REPEAT=1). Expected run results are queued when a run is launched;
// a negedge monitor checks the stim sequence while busy and pops/compares
// the run summary whenever done pulses.
module tb_truth_table_checker;

    logic clk = 1'b0;
    logic rst;
    logic start0, start1, start2;
    int   mode0;

    logic [2:0] stim0, stim1, stim2;
    logic [2:0] fvec0, fvec1, fvec2;
    logic [7:0] err0, err2;
    logic [2:0] err1;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic       pass0, pass1, pass2;
    logic       fev0, fev1, fev2;
    logic       dout0, dout1, dout2;

    always #5 clk = ~clk;

    function automatic logic maj(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // mode0: 0 = correct majority, 1 = wrong only at 5, 2 = always inverted
    assign dout0 = maj(stim0) ^ ((mode0 == 1) && (stim0 == 3'd5)) ^ (mode0 == 2);
    assign dout1 = ~maj(stim1);
    assign dout2 = maj(stim2);

    truth_table_checker u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .dut_out(dout0),
        .stim(stim0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_err_vec(fvec0), .first_err_valid(fev0)
    );

    truth_table_checker #(.CNT_W(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .dut_out(dout1),
        .stim(stim1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_vec(fvec1), .first_err_valid(fev1)
    );

    truth_table_checker #(.HOLD(1), .REPEAT(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .dut_out(dout2),
        .stim(stim2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_err_vec(fvec2), .first_err_valid(fev2)
    );

    typedef struct {
        int busy_len;
        int pass;
        int err;
        int fev;
        int fvec;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int d, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", name, d, got, exp, $time);
        end
    endtask

    // Per-instance views for the monitor loop.
    localparam int HOLD_OF [3] = '{2, 2, 1};
    logic [2:0] stim_a [3];
    logic [2:0] fvec_a [3];
    logic [7:0] err_a  [3];
    logic       busy_a [3];
    logic       done_a [3];
    logic       pass_a [3];
    logic       fev_a  [3];

    assign stim_a[0] = stim0; assign stim_a[1] = stim1; assign stim_a[2] = stim2;
    assign fvec_a[0] = fvec0; assign fvec_a[1] = fvec1; assign fvec_a[2] = fvec2;
    assign err_a[0]  = err0;  assign err_a[1]  = {5'b0, err1}; assign err_a[2] = err2;
    assign busy_a[0] = busy0; assign busy_a[1] = busy1; assign busy_a[2] = busy2;
    assign done_a[0] = done0; assign done_a[1] = done1; assign done_a[2] = done2;
    assign pass_a[0] = pass0; assign pass_a[1] = pass1; assign pass_a[2] = pass2;
    assign fev_a[0]  = fev0;  assign fev_a[1]  = fev1;  assign fev_a[2]  = fev2;

    int   blen  [3];
    logic dprev [3];

    // Monitor: stim sequence while busy, done width, run summary on done.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                blen[d]  = 0;
                dprev[d] = 1'b0;
            end else begin
                if (dprev[d]) chk("done_one_cycle", d, int'(done_a[d]), 0);
                dprev[d] = done_a[d];
                if (busy_a[d]) begin
                    chk("stim_seq", d, int'(stim_a[d]), (blen[d] / HOLD_OF[d]) % 8);
                    blen[d]++;
                end
                if (done_a[d]) begin
                    exp_t e;
                    int   n;
                    n = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
                    chk("queue_nonempty", d, (n > 0) ? 1 : 0, 1);
                    if (n > 0) begin
                        if (d == 0)      e = q0.pop_front();
                        else if (d == 1) e = q1.pop_front();
                        else             e = q2.pop_front();
                        chk("busy_len", d, blen[d], e.busy_len);
                        chk("pass", d, int'(pass_a[d]), e.pass);
                        chk("err_count", d, int'(err_a[d]), e.err);
                        chk("first_err_valid", d, int'(fev_a[d]), e.fev);
                        chk("first_err_vec", d, int'(fvec_a[d]), e.fvec);
                        chk("stim_after_run", d, int'(stim_a[d]), 0);
                        chk("busy_at_done", d, int'(busy_a[d]), 0);
                    end
                    blen[d] = 0;
                end
            end
        end
    end

    task automatic push_exp(input int d, input int bl, input int p, input int er,
                            input int fe, input int fv);
        exp_t e;
        e.busy_len = bl; e.pass = p; e.err = er; e.fev = fe; e.fvec = fv;
        if (d == 0)      q0.push_back(e);
        else if (d == 1) q1.push_back(e);
        else             q2.push_back(e);
    endtask

    task automatic pulse_start(input int d);
        @(negedge clk);
        if (d == 0) start0 = 1'b1; else if (d == 1) start1 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_a[d] && n < budget);
        if (!done_a[d]) begin
            checks++;
            errors++;
            $display("FAIL wait_done dut%0d: no done within %0d cycles", d, budget);
        end
    endtask

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; mode0 = 0;
        repeat (3) @(negedge clk);
        chk("rst_stim", 0, int'(stim0), 0);
        chk("rst_busy", 0, int'(busy0), 0);
        chk("rst_done", 0, int'(done0), 0);
        chk("rst_pass", 0, int'(pass0), 0);
        chk("rst_err", 0, int'(err0), 0);
        chk("rst_fev", 0, int'(fev0), 0);
        chk("rst_fvec", 0, int'(fvec0), 0);
        #2 rst = 1'b0;

        // Clean run with defaults.
        push_exp(0, 32, 1, 0, 0, 0);
        pulse_start(0);
        wait_done(0, 100);

        // Constantly inverted DUT, 3-bit saturating counter.
        push_exp(1, 32, 0, 7, 1, 0);
        pulse_start(1);
        wait_done(1, 100);

        // HOLD=1, REPEAT=1 clean run.
        push_exp(2, 8, 1, 0, 0, 0);
        pulse_start(2);
        wait_done(2, 50);

        // DUT wrong only at vector 5.
        mode0 = 1;
        push_exp(0, 32, 0, 2, 1, 5);
        pulse_start(0);
        wait_done(0, 100);

        // start held high with a glitch mid-run; relaunch after done.
        mode0 = 0;
        push_exp(0, 32, 1, 0, 0, 0);
        push_exp(0, 32, 1, 0, 0, 0);
        @(negedge clk);
        start0 = 1'b1;
        repeat (10) @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        start0 = 1'b1;
        wait_done(0, 100);
        @(negedge clk);
        chk("idle_gap_busy", 0, int'(busy0), 0);
        @(negedge clk);
        chk("relaunch_busy", 0, int'(busy0), 1);
        start0 = 1'b0;
        wait_done(0, 100);

        // Reset in the middle of a failing run.
        mode0 = 2;
        pulse_start(0);
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", 0, int'(busy0), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_stim", 0, int'(stim0), 0);
        chk("midrst_busy", 0, int'(busy0), 0);
        chk("midrst_err", 0, int'(err0), 0);
        chk("midrst_pass", 0, int'(pass0), 0);
        chk("midrst_fev", 0, int'(fev0), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        mode0 = 0;
        push_exp(0, 32, 1, 0, 0, 0);
        pulse_start(0);
        wait_done(0, 100);

        repeat (3) @(negedge clk);
        chk("q0_drained", 0, q0.size(), 0);
        chk("q1_drained", 1, q1.size(), 0);
        chk("q2_drained", 2, q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
